// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single main-memory block port between the I-cache and D-cache
//   controllers. In IDLE it picks one requester, with round-robin on ties. It
//   latches that requester's block command into registered mem_* outputs and
//   holds it until memory has raised and then dropped busywait. The loser stays
//   stalled. Read data is passed straight through to both caches. It is valid
//   to the winner in the cycle where that winner's busywait drops.
//
// Ports
//   clock, reset                  rising-edge clock, async active-low reset
//   ic_Read, ic_Address           I-cache block read request
//   ic_Readdata, ic_Busywait      I-cache return data / stall
//   dc_Read, dc_Write,
//   dc_Address, dc_Writedata      D-cache block read / write-back request
//   dc_Readdata, dc_Busywait      D-cache return data / stall
//   mem_Read, mem_Write,
//   mem_Address, mem_Writedata    registered command to memory
//   mem_Readdata, mem_Busywait    memory response
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ic_Read,
    input  logic [ADDR_WIDTH-1:0] ic_Address,
    output logic [DATA_WIDTH-1:0] ic_Readdata,
    output logic                  ic_Busywait,
    input  logic                  dc_Read,
    input  logic                  dc_Write,
    input  logic [ADDR_WIDTH-1:0] dc_Address,
    input  logic [DATA_WIDTH-1:0] dc_Writedata,
    output logic [DATA_WIDTH-1:0] dc_Readdata,
    output logic                  dc_Busywait,
    output logic                  mem_Read,
    output logic                  mem_Write,
    output logic [ADDR_WIDTH-1:0] mem_Address,
    output logic [DATA_WIDTH-1:0] mem_Writedata,
    input  logic [DATA_WIDTH-1:0] mem_Readdata,
    input  logic                  mem_Busywait
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;  // 0 = I, 1 = D
    logic                  seen_busy_q, seen_busy_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic ic_req, dc_req;
    logic done_i, done_d;

    assign ic_req = ic_Read;
    assign dc_req = dc_Read | dc_Write;

    // Memory may hold busywait low for a cycle or more after the strobe
    // appears. Completion is only recognised once busywait has actually been
    // seen high during this grant.
    assign done_i = (state_q == GRANT_I) & seen_busy_q & ~mem_Busywait;
    assign done_d = (state_q == GRANT_D) & seen_busy_q & ~mem_Busywait;

    assign ic_Busywait = ic_req & ~done_i;
    assign dc_Busywait = dc_req & ~done_d;

    assign ic_Readdata = mem_Readdata;
    assign dc_Readdata = mem_Readdata;

    assign mem_Read      = mem_read_q;
    assign mem_Write     = mem_write_q;
    assign mem_Address   = mem_addr_q;
    assign mem_Writedata = mem_wdata_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        seen_busy_d  = seen_busy_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            IDLE: begin
                // On a tie, I wins only if D had the previous grant.
                if (ic_req && (!dc_req || last_grant_q)) begin
                    state_d      = GRANT_I;
                    last_grant_d = 1'b0;
                    seen_busy_d  = 1'b0;
                    mem_read_d   = 1'b1;
                    mem_write_d  = 1'b0;
                    mem_addr_d   = ic_Address;
                    mem_wdata_d  = '0;
                end else if (dc_req) begin
                    state_d      = GRANT_D;
                    last_grant_d = 1'b1;
                    seen_busy_d  = 1'b0;
                    // A write-back takes priority over a read raised with it.
                    mem_read_d   = ~dc_Write;
                    mem_write_d  = dc_Write;
                    mem_addr_d   = dc_Address;
                    mem_wdata_d  = dc_Writedata;
                end
            end

            GRANT_I, GRANT_D: begin
                // The latched command is held even if the requester drops.
                if (done_i || done_d) begin
                    state_d     = IDLE;
                    seen_busy_d = 1'b0;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end else if (mem_Busywait) begin
                    seen_busy_d = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
            seen_busy_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            seen_busy_q  <= seen_busy_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. A small memory model raises busywait
//   one edge after seeing a strobe and holds it for mem_lat cycles. It then
//   returns a block derived from the address. The stimulus pushes expected
//   memory commands and expected requester completions into queues. A forked
//   monitor pops and compares them whenever a command starts or a requester
//   is released.
module tb_mem_port_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;

    logic          clock = 1'b0;
    logic          reset;
    logic          ic_Read;
    logic [AW-1:0] ic_Address;
    logic [DW-1:0] ic_Readdata;
    logic          ic_Busywait;
    logic          dc_Read, dc_Write;
    logic [AW-1:0] dc_Address;
    logic [DW-1:0] dc_Writedata;
    logic [DW-1:0] dc_Readdata;
    logic          dc_Busywait;
    logic          mem_Read, mem_Write;
    logic [AW-1:0] mem_Address;
    logic [DW-1:0] mem_Writedata;
    logic [DW-1:0] mem_Readdata;
    logic          mem_Busywait;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock(clock), .reset(reset),
        .ic_Read(ic_Read), .ic_Address(ic_Address),
        .ic_Readdata(ic_Readdata), .ic_Busywait(ic_Busywait),
        .dc_Read(dc_Read), .dc_Write(dc_Write), .dc_Address(dc_Address),
        .dc_Writedata(dc_Writedata), .dc_Readdata(dc_Readdata),
        .dc_Busywait(dc_Busywait),
        .mem_Read(mem_Read), .mem_Write(mem_Write), .mem_Address(mem_Address),
        .mem_Writedata(mem_Writedata), .mem_Readdata(mem_Readdata),
        .mem_Busywait(mem_Busywait)
    );

    always #5 clock = ~clock;

    // ---------------- memory model ----------------
    int   mem_lat = 3;
    int   mem_cnt;
    logic mem_served;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_Busywait <= 1'b0;
            mem_served   <= 1'b0;
            mem_cnt      <= 0;
            mem_Readdata <= '0;
        end else if (mem_Busywait) begin
            if (mem_cnt <= 1) begin
                mem_Busywait <= 1'b0;
                mem_served   <= 1'b1;
                if (mem_Read)
                    mem_Readdata <= (mem_Address == 28'h10) ? {16{8'hA5}}
                                                            : {4{{4'h0, mem_Address}}};
            end else begin
                mem_cnt <= mem_cnt - 1;
            end
        end else if ((mem_Read || mem_Write) && !mem_served) begin
            mem_Busywait <= 1'b1;
            mem_cnt      <= mem_lat;
        end else if (!(mem_Read || mem_Write)) begin
            mem_served <= 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } mem_exp_t;

    typedef struct packed {
        logic          side;      // 0 = I, 1 = D
        logic          chk_data;
        logic [DW-1:0] data;
    } cpl_exp_t;

    mem_exp_t mem_q[$];
    cpl_exp_t cpl_q[$];
    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errs++;
        $display("FAIL %s: event occurred, none expected / bound expired", name);
    endtask

    task automatic push_mem(input logic rd, input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd);
        mem_exp_t e;
        e.rd = rd; e.wr = wr; e.addr = a; e.wdata = wd;
        mem_q.push_back(e);
    endtask

    task automatic push_cpl(input logic side, input logic chk, input logic [DW-1:0] d);
        cpl_exp_t e;
        e.side = side; e.chk_data = chk; e.data = d;
        cpl_q.push_back(e);
    endtask

    task automatic cpl_check(input logic side, input logic [DW-1:0] d);
        cpl_exp_t e;
        if (cpl_q.size() == 0) begin
            fail(side ? "unexpected_dc_release" : "unexpected_ic_release");
        end else begin
            e = cpl_q.pop_front();
            check("release_side", 160'(side), 160'(e.side));
            if (e.chk_data) check("readdata", 160'(d), 160'(e.data));
        end
    endtask

    task automatic monitor();
        mem_exp_t cur;
        bit active = 1'b0;
        cur = '0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                active = 1'b0;
            end else begin
                if (mem_Read || mem_Write) begin
                    if (!active) begin
                        active = 1'b1;
                        if (mem_q.size() == 0) begin
                            fail("unexpected_mem_cmd");
                            cur = {mem_Read, mem_Write, mem_Address, mem_Writedata};
                        end else begin
                            cur = mem_q.pop_front();
                            check("mem_start_cmd", 160'({mem_Read, mem_Write}), 160'({cur.rd, cur.wr}));
                            check("mem_start_addr", 160'(mem_Address), 160'(cur.addr));
                            if (cur.wr) check("mem_start_wdata", 160'(mem_Writedata), 160'(cur.wdata));
                        end
                    end else begin
                        check("mem_hold_cmd", 160'({mem_Read, mem_Write}), 160'({cur.rd, cur.wr}));
                        check("mem_hold_addr", 160'(mem_Address), 160'(cur.addr));
                    end
                end else begin
                    active = 1'b0;
                end
                if (ic_Read && !ic_Busywait) cpl_check(1'b0, ic_Readdata);
                if ((dc_Read || dc_Write) && !dc_Busywait) cpl_check(1'b1, dc_Readdata);
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Wait for a requester's busywait to drop, then return just after the
    // done edge so the request can be changed like a cache would.
    task automatic wait_release(input logic side, input string name);
        bit got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clock);
            if (side ? !dc_Busywait : !ic_Busywait) got = 1'b1;
        end
        if (!got) fail(name);
        tick();
    endtask

    task automatic wait_strobe_low(input string name);
        bit got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clock);
            if (!mem_Read && !mem_Write) got = 1'b1;
        end
        if (!got) fail(name);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        ic_Read = 1'b0; ic_Address = '0;
        dc_Read = 1'b0; dc_Write = 1'b0; dc_Address = '0; dc_Writedata = '0;
        fork
            monitor();
        join_none

        // ---- reset state ----
        #1 reset = 1'b0;
        ic_Read = 1'b1;
        #1;
        check("rst_mem_read", 160'(mem_Read), 160'(0));
        check("rst_mem_write", 160'(mem_Write), 160'(0));
        check("rst_mem_addr", 160'(mem_Address), 160'(0));
        check("rst_mem_wdata", 160'(mem_Writedata), 160'(0));
        check("rst_ic_busy_eq_req", 160'(ic_Busywait), 160'(1));
        check("rst_dc_busy_eq_req", 160'(dc_Busywait), 160'(0));
        tick();
        check("rst_no_grant_on_edge", 160'(mem_Read), 160'(0));
        ic_Read = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // ---- tie after reset: D first, then I; second tie D again ----
        mem_lat = 3;
        push_mem(1, 0, 28'h200, '0); push_mem(1, 0, 28'h300, '0);
        push_cpl(1, 1, {4{32'h0000_0200}}); push_cpl(0, 1, {4{32'h0000_0300}});
        ic_Read = 1'b1; ic_Address = 28'h300;
        dc_Read = 1'b1; dc_Address = 28'h200;
        wait_release(1, "timeout_tie1_d");
        dc_Read = 1'b0;
        wait_release(0, "timeout_tie1_i");
        ic_Read = 1'b0;
        tick();

        push_mem(1, 0, 28'h400, '0); push_mem(1, 0, 28'h500, '0);
        push_cpl(1, 1, {4{32'h0000_0400}}); push_cpl(0, 1, {4{32'h0000_0500}});
        ic_Read = 1'b1; ic_Address = 28'h500;
        dc_Read = 1'b1; dc_Address = 28'h400;
        wait_release(1, "timeout_tie2_d");
        dc_Read = 1'b0;
        wait_release(0, "timeout_tie2_i");
        ic_Read = 1'b0;
        tick();

        // ---- I-only read ----
        mem_lat = 5;
        push_mem(1, 0, 28'h10, '0);
        push_cpl(0, 1, {16{8'hA5}});
        ic_Read = 1'b1; ic_Address = 28'h000_0010;
        tick();
        check("i_strobe_after_edge1", 160'({mem_Read, mem_Write}), 160'(2'b10));
        wait_release(0, "timeout_i_only");
        ic_Read = 1'b0;
        tick();

        // ---- D write-back ----
        push_mem(0, 1, 28'h123_4567, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);
        push_cpl(1, 0, '0);
        dc_Write = 1'b1; dc_Address = 28'h123_4567;
        dc_Writedata = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
        wait_release(1, "timeout_d_wb");
        dc_Write = 1'b0;
        tick();

        // ---- dirty miss: write-back, then I pending beats D's refill read ----
        mem_lat = 4;
        push_mem(0, 1, 28'h600, 128'h01234567_89ABCDEF_01234567_89ABCDEF);
        push_mem(1, 0, 28'h700, '0);
        push_mem(1, 0, 28'h800, '0);
        push_cpl(1, 0, '0);
        push_cpl(0, 1, {4{32'h0000_0700}});
        push_cpl(1, 1, {4{32'h0000_0800}});
        dc_Write = 1'b1; dc_Address = 28'h600;
        dc_Writedata = 128'h01234567_89ABCDEF_01234567_89ABCDEF;
        tick();
        tick();
        ic_Read = 1'b1; ic_Address = 28'h700;
        wait_release(1, "timeout_dirty_wb");
        dc_Write = 1'b0; dc_Read = 1'b1; dc_Address = 28'h800;
        wait_release(0, "timeout_dirty_i");
        ic_Read = 1'b0;
        wait_release(1, "timeout_dirty_d");
        dc_Read = 1'b0;
        tick();

        // ---- requester drops mid-grant ----
        mem_lat = 6;
        push_mem(1, 0, 28'h900, '0);
        ic_Read = 1'b1; ic_Address = 28'h900;
        tick();
        tick();
        ic_Read = 1'b0; ic_Address = 28'hFFF;
        wait_strobe_low("timeout_drop");
        tick();

        // ---- async reset mid GRANT_D write ----
        push_mem(0, 1, 28'hB00, 128'hCAFEF00D_CAFEF00D_CAFEF00D_CAFEF00D);
        dc_Write = 1'b1; dc_Address = 28'hB00;
        dc_Writedata = 128'hCAFEF00D_CAFEF00D_CAFEF00D_CAFEF00D;
        tick();
        tick();
        check("pre_rst_mem_write", 160'(mem_Write), 160'(1));
        tick();
        #2 reset = 1'b0;
        #1;
        check("async_rst_mem_write", 160'(mem_Write), 160'(0));
        check("async_rst_mem_addr", 160'(mem_Address), 160'(0));
        check("async_rst_dc_busy", 160'(dc_Busywait), 160'(1));
        dc_Write = 1'b0;
        #1;
        check("async_rst_dc_busy_drop", 160'(dc_Busywait), 160'(0));
        tick();
        tick();
        reset = 1'b1;
        tick();

        mem_lat = 3;
        push_mem(1, 0, 28'hC00, '0);
        push_cpl(0, 1, {4{32'h0000_0C00}});
        ic_Read = 1'b1; ic_Address = 28'hC00;
        wait_release(0, "timeout_post_rst_i");
        ic_Read = 1'b0;
        repeat (3) tick();

        check("mem_q_left", 160'(mem_q.size()), 160'(0));
        check("cpl_q_left", 160'(cpl_q.size()), 160'(0));

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
